game_flow_ctrl: RTL

GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

---
 rtl/game_flow_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/game_flow_ctrl.sv
// ============================================================================
// game_flow_ctrl : round FSM, shot/scroll pacing and BCD score for the bubble game.
// Optional macro GAME_TIMER_EN adds a per-round tick timer.  Rev 1.0
// ============================================================================
`default_nettype none

module game_flow_ctrl #(
  parameter int WIN_CNT        = 40,
  parameter int SCROLL_TICKS   = 8,
  parameter int SHOOT_COOLDOWN = 2,
  parameter int TIME_LIMIT     = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       tick,
  input  logic       jstk_press,
  input  logic [6:0] pop_cnt,
  input  logic       bubble_reached,
  output logic [1:0] state,
  output logic       play_en,
  output logic       clear_req,
  output logic       shoot_req,
  output logic       scroll_req,
  output logic [7:0] score_bcd,
  output logic [7:0] time_left,
  output logic       finish
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_WIN  = 2'd2,
    S_LOSE = 2'd3
  } state_e;

  localparam logic [6:0] c_win_cnt     = 7'(WIN_CNT);
  localparam logic [7:0] c_scroll_last = 8'(SCROLL_TICKS - 1);
  localparam logic [3:0] c_cooldown    = 4'(SHOOT_COOLDOWN);

  state_e     state_q, state_d;
  logic       en_q, en_prev_q, en_arm_q;
  logic       press_q, press_prev_q;
  logic [7:0] scroll_cnt_q;
  logic [3:0] cool_q;
  logic       play_en_q, clear_req_q, shoot_req_q, scroll_req_q, finish_q;
  logic [7:0] score_q;

  logic       w_en_rise, w_press_rise, w_win, w_in_play, w_timeout;
  logic [6:0] w_sat;
  logic [3:0] w_tens, w_ones;

  // en_arm_q blocks a round start until en has been seen low after reset.
  assign w_en_rise    = en_q & ~en_prev_q & en_arm_q;
  assign w_press_rise = press_q & ~press_prev_q;
  assign w_win        = (pop_cnt >= c_win_cnt);

`ifdef GAME_TIMER_EN
  localparam logic [7:0] c_time_limit = 8'(TIME_LIMIT);
  logic [7:0] time_q;
  assign w_timeout = (time_q == 8'd0);
  assign time_left = time_q;
`else
  assign w_timeout = 1'b0;
  assign time_left = 8'(TIME_LIMIT) & 8'h00;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:        if (w_en_rise) state_d = S_PLAY;
      S_PLAY: begin
        if (w_win)               state_d = S_WIN;
        else if (bubble_reached) state_d = S_LOSE;
        else if (w_timeout)      state_d = S_LOSE;
      end
      S_WIN, S_LOSE: if (w_en_rise) state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase
  end

  assign w_in_play = (state_q == S_PLAY) && (state_d == S_PLAY);
  assign w_sat     = (pop_cnt > 7'd99) ? 7'd99 : pop_cnt;
  assign w_tens    = 4'(w_sat / 7'd10);
  assign w_ones    = 4'(w_sat % 7'd10);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      en_q         <= 1'b0;
      en_prev_q    <= 1'b0;
      en_arm_q     <= 1'b0;
      press_q      <= 1'b0;
      press_prev_q <= 1'b0;
      scroll_cnt_q <= 8'd0;
      cool_q       <= 4'd0;
      play_en_q    <= 1'b0;
      clear_req_q  <= 1'b0;
      shoot_req_q  <= 1'b0;
      scroll_req_q <= 1'b0;
      finish_q     <= 1'b0;
      score_q      <= 8'd0;
`ifdef GAME_TIMER_EN
      time_q       <= 8'd0;
`endif
    end else begin
      en_q         <= en;
      en_prev_q    <= en_q;
      en_arm_q     <= en_arm_q | ~en;
      press_q      <= jstk_press;
      press_prev_q <= press_q;
      state_q      <= state_d;
      play_en_q    <= (state_d == S_PLAY);
      finish_q     <= (state_d == S_WIN) || (state_d == S_LOSE);
      clear_req_q  <= (state_q == S_IDLE) && (state_d == S_PLAY);
      score_q      <= {w_tens, w_ones};
      shoot_req_q  <= 1'b0;
      scroll_req_q <= 1'b0;
      if (w_in_play) begin
        if (tick) begin
          if (scroll_cnt_q >= c_scroll_last) begin
            scroll_cnt_q <= 8'd0;
            scroll_req_q <= 1'b1;
          end else begin
            scroll_cnt_q <= scroll_cnt_q + 8'd1;
          end
        end
        if (w_press_rise && (cool_q == 4'd0)) begin
          shoot_req_q <= 1'b1;
          cool_q      <= c_cooldown;
        end else if (tick && (cool_q != 4'd0)) begin
          cool_q <= cool_q - 4'd1;
        end
      end else begin
        scroll_cnt_q <= 8'd0;
        cool_q       <= 4'd0;
      end
`ifdef GAME_TIMER_EN
      if ((state_q == S_IDLE) && (state_d == S_PLAY))
        time_q <= c_time_limit;
      else if (w_in_play && tick && (time_q != 8'd0))
        time_q <= time_q - 8'd1;
`endif
    end
  end

  assign state      = state_q;
  assign play_en    = play_en_q;
  assign clear_req  = clear_req_q;
  assign shoot_req  = shoot_req_q;
  assign scroll_req = scroll_req_q;
  assign score_bcd  = score_q;
  assign finish     = finish_q;

endmodule

`default_nettype wire
